// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg                                                                     |
// | Shared definitions for the fetch stage: HALT opcode location and the        |
// | fetch FSM state type.                                                       |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
package cpu_pkg;

   localparam logic [3:0] OP_HALT     = 4'b1111;
   localparam int         OP_FIELD_HI = 27;
   localparam int         OP_FIELD_LO = 24;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      VALID = 3'd2,
      DRAIN = 3'd3,
      HALT  = 3'd4
   } fetch_state_t;

   function automatic logic is_halt(input logic [31:0] word);
      return word[OP_FIELD_HI:OP_FIELD_LO] == OP_HALT;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_pc                                                                    |
// | Program counter and outstanding-request address registers.                  |
// |   clk, reset       : clock, asynchronous active-low reset                     |
// |   load, load_addr  : redirect pc (highest priority)                          |
// |   inc, inc_base    : pc <= inc_base + 1, wrapping modulo 2^ADDR_W            |
// |   req_capture      : req_addr <= pc (request being issued this cycle)        |
// |   pc, req_addr     : register outputs                                       |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module fetch_pc
   import cpu_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc,
   input  logic [ADDR_W-1:0] inc_base,
   input  logic              req_capture,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] req_addr
);

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] pc_d, pc_q;
   logic [ADDR_W-1:0] req_addr_d, req_addr_q;

   always_comb begin
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      // Addition is truncated to ADDR_W bits, so FFFF+1 wraps to 0000.
      if (load)
         pc_d = load_addr;
      else if (inc)
         pc_d = inc_base + ONE;
      if (req_capture)
         req_addr_d = pc_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= BOOT_ADDR;
         req_addr_q <= BOOT_ADDR;
      end else begin
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   assign pc       = pc_q;
   assign req_addr = req_addr_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit                                                                  |
// | Instruction fetch stage: owns the PC, reads instruction memory over an     |
// | en/ready handshake and presents one instruction word with a valid flag.    |
// |   imem_en/addr/rdata/ready : instruction memory request channel            |
// |   stall                    : downstream cannot take `code` this cycle       |
// |   branch_valid/target      : single-cycle redirect                         |
// |   code/code_valid/counter  : instruction, valid flag, its fetch address     |
// |   halted                   : HALT consumed, fetch stopped until reset      |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              imem_ready,
   input  logic              stall,
   input  logic              branch_valid,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [DATA_W-1:0] code,
   output logic              code_valid,
   output logic [ADDR_W-1:0] counter,
   output logic              halted
);

   fetch_state_t      state_d, state_q;
   logic [DATA_W-1:0] code_d, code_q;
   logic [ADDR_W-1:0] counter_d, counter_q;
   logic              code_valid_d, code_valid_q;
   logic              halted_d, halted_q;

   logic              pc_load, pc_inc, req_capture, accept;
   logic [ADDR_W-1:0] pc, req_addr;

   fetch_pc #(
      .ADDR_W    (ADDR_W),
      .BOOT_ADDR (BOOT_ADDR)
   ) u_fetch_pc (
      .clk         (clk),
      .reset       (reset),
      .load        (pc_load),
      .load_addr   (branch_target),
      .inc         (pc_inc),
      .inc_base    (imem_addr),
      .req_capture (req_capture),
      .pc          (pc),
      .req_addr    (req_addr)
   );

   // DRAIN must keep presenting the orphaned request's address until it completes.
   assign imem_addr = (state_q == DRAIN) ? req_addr : pc;

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      counter_d   = counter_q;
      imem_en     = 1'b0;
      pc_load     = 1'b0;
      req_capture = 1'b0;
      accept      = 1'b0;

      unique case (state_q)
         IDLE: begin
            pc_load = branch_valid;
            state_d = REQ;
         end
         REQ: begin
            // The request is already on the bus, so it stays asserted even when
            // a branch arrives; its data is simply not accepted.
            imem_en     = 1'b1;
            req_capture = 1'b1;
            if (branch_valid) begin
               pc_load = 1'b1;
               state_d = imem_ready ? REQ : DRAIN;
            end else if (imem_ready) begin
               accept  = 1'b1;
               state_d = VALID;
            end
         end
         VALID: begin
            if (branch_valid) begin
               pc_load = 1'b1;
               state_d = REQ;
            end else if (stall) begin
               state_d = VALID;
            end else if (is_halt(code_q[31:0])) begin
               state_d = HALT;
            end else begin
               imem_en     = 1'b1;
               req_capture = 1'b1;
               if (imem_ready)
                  accept = 1'b1;
               else
                  state_d = REQ;
            end
         end
         DRAIN: begin
            imem_en = 1'b1;
            pc_load = branch_valid;
            if (imem_ready)
               state_d = REQ;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      pc_inc = accept;
      if (accept) begin
         code_d    = imem_rdata;
         counter_d = imem_addr;
      end

      code_valid_d = (state_d == VALID);
      halted_d     = (state_d == HALT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         code_q       <= '0;
         counter_q    <= '0;
         code_valid_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         code_q       <= code_d;
         counter_q    <= counter_d;
         code_valid_q <= code_valid_d;
         halted_q     <= halted_d;
      end
   end

   assign code       = code_q;
   assign counter    = counter_q;
   assign code_valid = code_valid_q;
   assign halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_unit                                                               |
// | Directed self-checking bench for fetch_unit. Memory model: mem[a] = a,      |
// | except a HALT word at 0x0010.                                               |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_en;
   logic [15:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready = 1'b1;
   logic        stall = 1'b0;
   logic        branch_valid = 1'b0;
   logic [15:0] branch_target = 16'h0;
   logic [31:0] code;
   logic        code_valid;
   logic [15:0] counter;
   logic        halted;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return (a == 16'h0010) ? 32'h0F00_0010 : {16'h0000, a};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   fetch_unit #(.ADDR_W(16), .DATA_W(32), .BOOT_ADDR(16'h0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_en       (imem_en),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_ready    (imem_ready),
      .stall         (stall),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .code          (code),
      .code_valid    (code_valid),
      .counter       (counter),
      .halted        (halted)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) step();
      #1;
      checks++;
      if ({code_valid, imem_en, halted} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 000", {code_valid, imem_en, halted});
      end
      checks++;
      if ({code, counter, imem_addr} !== 64'h0) begin
         errors++;
         $display("FAIL reset_regs got code=%h counter=%h addr=%h exp all 0", code, counter, imem_addr);
      end
   endtask

   task automatic test_stream();
      reset = 1'b1;
      step();  // IDLE -> REQ
      #1;
      checks++;
      if ({code_valid, imem_en, imem_addr} !== {2'b01, 16'h0000}) begin
         errors++;
         $display("FAIL first_req got valid=%b en=%b addr=%h exp 0 1 0000", code_valid, imem_en, imem_addr);
      end
      for (int k = 0; k < 5; k++) begin
         step();
         #1;
         checks++;
         if ({code_valid, code, counter} !== {1'b1, 32'(k), 16'(k)}) begin
            errors++;
            $display("FAIL stream_%0d got valid=%b code=%h counter=%h exp 1 %h %h",
                     k, code_valid, code, counter, 32'(k), 16'(k));
         end
      end
   endtask

   task automatic test_wait();
      imem_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            step();
            #1;
         end
         checks++;
         if ({imem_en, imem_addr} !== {1'b1, 16'h0005} || (i > 0 && code_valid !== 1'b0)) begin
            errors++;
            $display("FAIL wait_%0d got en=%b addr=%h valid=%b exp 1 0005 %b",
                     i, imem_en, imem_addr, code_valid, (i == 0));
         end
      end
      step();
      imem_ready = 1'b1;
      #1;
      step();
      #1;
      checks++;
      if ({code_valid, code, counter} !== {1'b1, 32'h5, 16'h5}) begin
         errors++;
         $display("FAIL wait_data got valid=%b code=%h counter=%h exp 1 00000005 0005", code_valid, code, counter);
      end
   endtask

   task automatic test_stall();
      repeat (2) step();
      stall = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            step();
            #1;
         end
         checks++;
         if ({code_valid, imem_en, code, counter} !== {2'b10, 32'h7, 16'h7}) begin
            errors++;
            $display("FAIL stall_%0d got valid=%b en=%b code=%h counter=%h exp 1 0 00000007 0007",
                     i, code_valid, imem_en, code, counter);
         end
      end
      step();
      stall = 1'b0;
      #1;
      checks++;
      if ({imem_en, imem_addr} !== {1'b1, 16'h0008}) begin
         errors++;
         $display("FAIL stall_resume got en=%b addr=%h exp 1 0008", imem_en, imem_addr);
      end
      step();
      #1;
      checks++;
      if ({code_valid, code, counter} !== {1'b1, 32'h8, 16'h8}) begin
         errors++;
         $display("FAIL stall_next got valid=%b code=%h counter=%h exp 1 00000008 0008", code_valid, code, counter);
      end
   endtask

   task automatic test_branch_drain();
      imem_ready = 1'b0;
      #1;
      step();  // VALID -> REQ at 9
      branch_valid  = 1'b1;
      branch_target = 16'h0040;
      #1;
      step();  // REQ + branch + not ready -> DRAIN
      branch_valid = 1'b0;
      #1;
      checks++;
      if ({code_valid, imem_en, imem_addr} !== {2'b01, 16'h0009}) begin
         errors++;
         $display("FAIL drain_hold got valid=%b en=%b addr=%h exp 0 1 0009", code_valid, imem_en, imem_addr);
      end
      step();
      imem_ready = 1'b1;
      #1;
      step();  // drain completes, data discarded
      #1;
      checks++;
      if ({code_valid, imem_en, imem_addr, code} !== {2'b01, 16'h0040, 32'h8}) begin
         errors++;
         $display("FAIL drain_done got valid=%b en=%b addr=%h code=%h exp 0 1 0040 00000008",
                  code_valid, imem_en, imem_addr, code);
      end
      step();
      #1;
      checks++;
      if ({code_valid, code, counter} !== {1'b1, 32'h40, 16'h0040}) begin
         errors++;
         $display("FAIL branch_target got valid=%b code=%h counter=%h exp 1 00000040 0040", code_valid, code, counter);
      end
   endtask

   task automatic test_wrap_halt();
      branch_valid  = 1'b1;
      branch_target = 16'hFFFF;
      #1;
      checks++;
      if (imem_en !== 1'b0) begin
         errors++;
         $display("FAIL branch_no_req got en=%b exp 0", imem_en);
      end
      step();
      branch_valid = 1'b0;
      #1;
      step();
      #1;
      checks++;
      if ({code_valid, code, counter} !== {1'b1, 32'h0000_FFFF, 16'hFFFF}) begin
         errors++;
         $display("FAIL wrap_ffff got valid=%b code=%h counter=%h exp 1 0000ffff ffff", code_valid, code, counter);
      end
      step();
      #1;
      checks++;
      if ({code_valid, code, counter} !== {1'b1, 32'h0, 16'h0000}) begin
         errors++;
         $display("FAIL wrap_0000 got valid=%b code=%h counter=%h exp 1 00000000 0000", code_valid, code, counter);
      end
      branch_valid  = 1'b1;
      branch_target = 16'h000E;
      #1;
      step();
      branch_valid = 1'b0;
      #1;
      repeat (3) step();  // accept 0E, 0F, 10
      #1;
      checks++;
      if ({code_valid, imem_en, code, counter} !== {2'b10, 32'h0F00_0010, 16'h0010}) begin
         errors++;
         $display("FAIL halt_word got valid=%b en=%b code=%h counter=%h exp 1 0 0f000010 0010",
                  code_valid, imem_en, code, counter);
      end
      step();
      branch_valid  = 1'b1;
      branch_target = 16'h0020;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         #1;
         checks++;
         if ({halted, code_valid, imem_en} !== 3'b100) begin
            errors++;
            $display("FAIL halted_%0d got halted=%b valid=%b en=%b exp 1 0 0", i, halted, code_valid, imem_en);
         end
      end
      branch_valid = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if ({halted, imem_en, imem_addr} !== {2'b00, 16'h0000}) begin
         errors++;
         $display("FAIL halt_reset got halted=%b en=%b addr=%h exp 0 0 0000", halted, imem_en, imem_addr);
      end
      step();
      reset = 1'b1;
      #1;
      step();
      #1;
      checks++;
      if ({imem_en, imem_addr} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL recover_req got en=%b addr=%h exp 1 0000", imem_en, imem_addr);
      end
      step();
      #1;
      checks++;
      if ({code_valid, code, counter} !== {1'b1, 32'h0, 16'h0}) begin
         errors++;
         $display("FAIL recover_code got valid=%b code=%h counter=%h exp 1 00000000 0000", code_valid, code, counter);
      end
   endtask

   task automatic test_reset_in_valid();
      step();
      #1;
      checks++;
      if ({code_valid, code} !== {1'b1, 32'h1}) begin
         errors++;
         $display("FAIL pre_reset got valid=%b code=%h exp 1 00000001", code_valid, code);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({code_valid, imem_en, imem_addr, code, counter} !== {2'b00, 16'h0, 32'h0, 16'h0}) begin
         errors++;
         $display("FAIL async_reset got valid=%b en=%b addr=%h code=%h counter=%h exp all 0",
                  code_valid, imem_en, imem_addr, code, counter);
      end
      step();
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_wait();
      test_stall();
      test_branch_drain();
      test_wrap_halt();
      test_reset_in_valid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
